// File: rtl/epl_ffram02_scrub_ctrl_pkg.sv
// rtl/epl_ffram02_scrub_ctrl_pkg.sv - FFRAM02 shared geometry, FSM encodings and helpers
// Defines : `ADDR_WIDTH, `WORD_WIDTH, `WORD, `FAULT (macro geometry)
//           `FFRAM02_ST_* (controller state codes)
// Package : width localparams, state_t, next_scrub_addr()
`ifndef FFRAM02_SPEC_SVH
`define FFRAM02_SPEC_SVH
`define ADDR_WIDTH 4
`define WORD_WIDTH 4
`define WORD 16
`define FAULT 1
`define FFRAM02_ST_IDLE  3'd0
`define FFRAM02_ST_H_RD  3'd1
`define FFRAM02_ST_H_WR  3'd2
`define FFRAM02_ST_S_RD  3'd3
`define FFRAM02_ST_S_WB  3'd4
`define FFRAM02_ST_S_WBW 3'd5
`endif

package epl_ffram02_scrub_ctrl_pkg;
   localparam int ADDR_W    = `ADDR_WIDTH;
   localparam int DATA_W    = `WORD_WIDTH;
   localparam int NUM_WORDS = `WORD;
   localparam int FS_W      = `FAULT;
   localparam int TIMER_W   = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = `FFRAM02_ST_IDLE,
      ST_H_RD  = `FFRAM02_ST_H_RD,
      ST_H_WR  = `FFRAM02_ST_H_WR,
      ST_S_RD  = `FFRAM02_ST_S_RD,
      ST_S_WB  = `FFRAM02_ST_S_WB,
      ST_S_WBW = `FFRAM02_ST_S_WBW
   } state_t;

   // Scrub walk wraps at the last word rather than at the address-field limit.
   function automatic logic [ADDR_W-1:0] next_scrub_addr(input logic [ADDR_W-1:0] a);
      return (a == ADDR_W'(NUM_WORDS - 1)) ? '0 : a + ADDR_W'(1);
   endfunction
endpackage

// File: rtl/epl_ffram02_scrub_ctrl_timer.sv
// rtl/epl_ffram02_scrub_ctrl_timer.sv - scrub interval timer with pending flag
// pCLK_r : clock           nRST_r : async active-low reset
// en     : scrub enable    clr    : scrub completed, drop pending
// pend   : scrub request pending
module epl_scrub_timer
   import epl_ffram02_scrub_ctrl_pkg::*;
#(
   parameter int SCRUB_INTERVAL = 64
) (
   input  logic pCLK_r,
   input  logic nRST_r,
   input  logic en,
   input  logic clr,
   output logic pend
);
   localparam logic [TIMER_W-1:0] LAST = TIMER_W'(SCRUB_INTERVAL - 1);

   logic [TIMER_W-1:0] cnt_r;

   // A new request on the wrap edge takes priority over a completion clear.
   always_ff @(posedge pCLK_r or negedge nRST_r) begin
      if (!nRST_r) begin
         cnt_r <= '0;
         pend  <= 1'b0;
      end else if (!en) begin
         cnt_r <= '0;
         pend  <= 1'b0;
      end else if (cnt_r == LAST) begin
         cnt_r <= '0;
         pend  <= 1'b1;
      end else begin
         cnt_r <= cnt_r + TIMER_W'(1);
         if (clr) pend <= 1'b0;
      end
   end
endmodule

// File: rtl/epl_ffram02_scrub_ctrl.sv
// rtl/epl_ffram02_scrub_ctrl.sv - FFRAM02 access controller with background scrubber
// Host   : pHreq_i/pHwe_i/pHaddr_i/pHdata_i/pHfs_i in, pHack_o/pHrdata_o/pHerr_o out
// Macro  : pA_o/pD_o/nWEN_o/nCEN_o/pFS_o registered command, pQ_i/pERR_i read return
// Scrub  : pScrubEn_i enable, pScrubAddr_o next address, pCorrCnt_o write-back count
// Status : pBusy_o high outside IDLE
module epl_ffram02_scrub_ctrl
   import epl_ffram02_scrub_ctrl_pkg::*;
#(
   parameter int RD_LAT         = 4,
   parameter int WR_LAT         = 2,
   parameter int SCRUB_INTERVAL = 64,
   parameter int CNT_W          = 8
) (
   input  logic                   pCLOCK_i,
   input  logic                   nRESET_i,
   input  logic                   pHreq_i,
   input  logic                   pHwe_i,
   input  logic [`ADDR_WIDTH-1:0] pHaddr_i,
   input  logic [`WORD_WIDTH-1:0] pHdata_i,
   input  logic [`FAULT-1:0]      pHfs_i,
   output logic                   pHack_o,
   output logic [`WORD_WIDTH-1:0] pHrdata_o,
   output logic                   pHerr_o,
   input  logic                   pScrubEn_i,
   output logic [`ADDR_WIDTH-1:0] pA_o,
   output logic [`WORD_WIDTH-1:0] pD_o,
   output logic                   nWEN_o,
   output logic                   nCEN_o,
   output logic [`FAULT-1:0]      pFS_o,
   input  logic [`WORD_WIDTH-1:0] pQ_i,
   input  logic                   pERR_i,
   output logic                   pBusy_o,
   output logic [`ADDR_WIDTH-1:0] pScrubAddr_o,
   output logic [CNT_W-1:0]       pCorrCnt_o
);
   localparam int LAT_W = 8;
   localparam logic [LAT_W-1:0] RD_L = LAT_W'(RD_LAT);
   localparam logic [LAT_W-1:0] WR_L = LAT_W'(WR_LAT);

   state_t              state_r, state_nxt;
   logic [LAT_W-1:0]    lat_cnt_r;
   logic [DATA_W-1:0]   wb_data_r;
   logic                last_host_r, pend_at_grant_r;
   logic                scrub_pend, host_req, grant_scrub, grant_host, lat_done;

   logic                issue, cmd_we, grant, ack_set, rd_latch, wb_latch, scrub_done, corr_inc;
   logic [ADDR_W-1:0]   cmd_addr;
   logic [DATA_W-1:0]   cmd_data;
   logic [FS_W-1:0]     cmd_fs;
   logic [LAT_W-1:0]    lat_load;

   epl_scrub_timer #(.SCRUB_INTERVAL(SCRUB_INTERVAL)) u_timer (
      .pCLK_r (pCLOCK_i),
      .nRST_r (nRESET_i),
      .en     (pScrubEn_i),
      .clr    (scrub_done),
      .pend   (scrub_pend)
   );

   // The ack cycle masks the host request so a held request is not re-granted.
   assign host_req    = pHreq_i & ~pHack_o;
   // Scrub yields to the host unless it already waited through the last host grant.
   assign grant_scrub = scrub_pend & (~host_req | (last_host_r & pend_at_grant_r));
   assign grant_host  = host_req & ~grant_scrub;
   assign lat_done    = (lat_cnt_r == '0);
   assign pBusy_o     = (state_r != ST_IDLE);

   always_ff @(posedge pCLOCK_i or negedge nRESET_i) begin
      if (!nRESET_i) state_r <= ST_IDLE;
      else           state_r <= state_nxt;
   end

   always_comb begin
      state_nxt = state_r;
      case (state_r)
         ST_IDLE:  if (grant_scrub)     state_nxt = ST_S_RD;
                   else if (grant_host) state_nxt = pHwe_i ? ST_H_WR : ST_H_RD;
         ST_H_RD:  if (lat_done) state_nxt = ST_IDLE;
         ST_H_WR:  if (lat_done) state_nxt = ST_IDLE;
         ST_S_RD:  if (lat_done) state_nxt = pERR_i ? ST_S_WB : ST_IDLE;
         ST_S_WB:  state_nxt = ST_S_WBW;
         ST_S_WBW: if (lat_done) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      issue      = 1'b0;
      cmd_we     = 1'b0;
      cmd_addr   = '0;
      cmd_data   = '0;
      cmd_fs     = '0;
      lat_load   = '0;
      grant      = 1'b0;
      ack_set    = 1'b0;
      rd_latch   = 1'b0;
      wb_latch   = 1'b0;
      scrub_done = 1'b0;
      corr_inc   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (grant_scrub) begin
               issue    = 1'b1;
               grant    = 1'b1;
               cmd_addr = pScrubAddr_o;
               lat_load = RD_L;
            end else if (grant_host) begin
               issue    = 1'b1;
               grant    = 1'b1;
               cmd_we   = pHwe_i;
               cmd_addr = pHaddr_i;
               cmd_data = pHdata_i;
               cmd_fs   = pHfs_i;
               lat_load = pHwe_i ? WR_L : RD_L;
            end
         end
         ST_H_RD: if (lat_done) begin
            ack_set  = 1'b1;
            rd_latch = 1'b1;
         end
         ST_H_WR: if (lat_done) ack_set = 1'b1;
         ST_S_RD: if (lat_done) begin
            wb_latch   = pERR_i;
            scrub_done = ~pERR_i;
         end
         ST_S_WB: begin
            issue    = 1'b1;
            cmd_we   = 1'b1;
            cmd_addr = pScrubAddr_o;
            cmd_data = wb_data_r;
            lat_load = WR_L;
            corr_inc = 1'b1;
         end
         ST_S_WBW: if (lat_done) scrub_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge pCLOCK_i or negedge nRESET_i) begin
      if (!nRESET_i) begin
         nCEN_o          <= 1'b1;
         nWEN_o          <= 1'b1;
         pA_o            <= '0;
         pD_o            <= '0;
         pFS_o           <= '0;
         lat_cnt_r       <= '0;
         pHack_o         <= 1'b0;
         pHrdata_o       <= '0;
         pHerr_o         <= 1'b0;
         wb_data_r       <= '0;
         pScrubAddr_o    <= '0;
         pCorrCnt_o      <= '0;
         last_host_r     <= 1'b0;
         pend_at_grant_r <= 1'b0;
      end else begin
         nCEN_o  <= ~issue;
         nWEN_o  <= ~(issue & cmd_we);
         pA_o    <= cmd_addr;
         pD_o    <= cmd_data;
         pFS_o   <= cmd_fs;
         pHack_o <= ack_set;
         if (issue)               lat_cnt_r <= lat_load;
         else if (!lat_done)      lat_cnt_r <= lat_cnt_r - LAT_W'(1);
         if (rd_latch) begin
            pHrdata_o <= pQ_i;
            pHerr_o   <= pERR_i;
         end
         if (wb_latch)   wb_data_r    <= pQ_i;
         if (scrub_done) pScrubAddr_o <= next_scrub_addr(pScrubAddr_o);
         if (corr_inc && (pCorrCnt_o != '1)) pCorrCnt_o <= pCorrCnt_o + CNT_W'(1);
         if (grant) begin
            last_host_r     <= grant_host;
            pend_at_grant_r <= scrub_pend;
         end
      end
   end
endmodule

// File: tb/tb_epl_ffram02_scrub_ctrl.sv
// tb/tb_epl_ffram02_scrub_ctrl.sv - directed self-checking bench for epl_ffram02_scrub_ctrl
module tb_epl_ffram02_scrub_ctrl;
   localparam int RD_LAT = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       hreq = 1'b0, hwe = 1'b0;
   logic [3:0] haddr = '0, hdata = '0;
   logic [0:0] hfs = '0;
   logic       hack, herr, scrub_en = 1'b0;
   logic [3:0] hrdata, pa, pd, pq, saddr;
   logic       nwen, ncen, perr, busy;
   logic [0:0] pfs;
   logic [7:0] corr;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int wr_cmds = 0;

   logic [3:0] mem [16];
   logic       flt [16];
   logic       force_err = 1'b0;
   int         rd_age = 0;
   logic [3:0] rd_addr = '0;

   epl_ffram02_scrub_ctrl #(.RD_LAT(4), .WR_LAT(2), .SCRUB_INTERVAL(8), .CNT_W(8)) dut (
      .pCLOCK_i(clk), .nRESET_i(rst_n),
      .pHreq_i(hreq), .pHwe_i(hwe), .pHaddr_i(haddr), .pHdata_i(hdata), .pHfs_i(hfs),
      .pHack_o(hack), .pHrdata_o(hrdata), .pHerr_o(herr), .pScrubEn_i(scrub_en),
      .pA_o(pa), .pD_o(pd), .nWEN_o(nwen), .nCEN_o(ncen), .pFS_o(pfs),
      .pQ_i(pq), .pERR_i(perr), .pBusy_o(busy), .pScrubAddr_o(saddr), .pCorrCnt_o(corr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) if (!ncen && !nwen) wr_cmds++;

   // Macro model: fault-select writes leave a correctable upset in the word;
   // read data is only driven in the cycle ending RD_LAT edges after the sample edge.
   always @(posedge clk) begin
      if (!ncen && !nwen) begin
         mem[pa] <= pd;
         flt[pa] <= pfs[0];
      end
      if (!ncen && nwen) begin
         rd_addr <= pa;
         rd_age  <= 1;
      end else if (rd_age == RD_LAT) rd_age <= 0;
      else if (rd_age != 0)          rd_age <= rd_age + 1;
   end
   assign pq   = (rd_age == RD_LAT) ? mem[rd_addr] : 4'h0;
   assign perr = (rd_age == RD_LAT) ? (flt[rd_addr] | force_err) : 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Raises the request in the current cycle; lat counts edges from the first sampling edge.
   task automatic host_op(input logic we, input logic [3:0] a, input logic [3:0] d,
                          input logic fs, output int lat, output logic [3:0] rd,
                          output logic er);
      int start;
      bit got;
      hreq = 1'b1; hwe = we; haddr = a; hdata = d; hfs = fs;
      start = cyc; got = 0; lat = -1; rd = 4'h0; er = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (hack) begin
            lat = cyc - start - 1; rd = hrdata; er = herr; got = 1;
            break;
         end
      end
      hreq = 1'b0;
      chk("host_ack_seen", 32'(got), 1);
   endtask

   task automatic wait_cmd(input logic want_we, input int budget, output bit got);
      got = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!ncen && (nwen == !want_we)) begin
            got = 1;
            break;
         end
      end
   endtask

   initial begin
      int lat, n, prev, wbn, last_rd;
      logic [3:0] rd;
      logic er;
      bit got;
      for (int i = 0; i < 16; i++) begin
         mem[i] = 4'h0;
         flt[i] = 1'b0;
      end

      repeat (3) @(negedge clk);
      chk("reset_vec", 32'({ncen, nwen, pa, pd, pfs, hack, hrdata, herr, busy, saddr, corr}),
          32'h3000_0000);
      rst_n = 1'b1;

      host_op(1'b1, 4'h3, 4'hA, 1'b0, lat, rd, er);
      chk("wr_lat", 32'(lat), 3);
      chk("cmd_idle_after_wr", 32'({ncen, nwen}), 32'h3);
      @(negedge clk);
      host_op(1'b0, 4'h3, 4'h0, 1'b0, lat, rd, er);
      chk("rd_lat", 32'(lat), 5);
      chk("rd_data", 32'(rd), 32'hA);
      chk("rd_err", 32'(er), 0);
      chk("corr_after_host", 32'(corr), 0);

      @(negedge clk);
      scrub_en = 1'b1; n = cyc; prev = 0;
      for (int k = 0; k < 17; k++) begin
         wait_cmd(1'b0, 40, got);
         chk("scrub_rd_seen", 32'(got), 1);
         chk("scrub_rd_addr", 32'(pa), 32'(k % 16));
         chk("scrub_addr_out", 32'(saddr), 32'(k % 16));
         if (k == 0) chk("scrub_first_delay", 32'(cyc - n), 9);
         else        chk("scrub_period", 32'(cyc - prev), 8);
         prev = cyc;
      end
      scrub_en = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      chk("clean_no_writes", 32'(wr_cmds), 1);
      chk("clean_corr", 32'(corr), 0);
      chk("scrub_addr_wrapped", 32'(saddr), 1);

      @(negedge clk);
      host_op(1'b1, 4'h4, 4'hE, 1'b1, lat, rd, er);
      chk("fault_wr_lat", 32'(lat), 3);
      @(negedge clk);
      scrub_en = 1'b1; got = 0; last_rd = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!ncen && nwen) last_rd = cyc;
         if (!ncen && !nwen) begin
            got = 1;
            break;
         end
      end
      chk("wb_seen", 32'(got), 1);
      chk("wb_addr", 32'(pa), 32'h4);
      chk("wb_data", 32'(pd), 32'hE);
      chk("wb_fs", 32'(pfs), 0);
      chk("wb_delay", 32'(cyc - last_rd), 6);
      scrub_en = 1'b0;
      repeat (5) @(negedge clk);
      chk("corr_one", 32'(corr), 1);
      chk("addr_after_wb", 32'(saddr), 5);
      host_op(1'b0, 4'h4, 4'h0, 1'b0, lat, rd, er);
      chk("repaired_data", 32'(rd), 32'hE);
      chk("repaired_err", 32'(er), 0);

      @(negedge clk);
      scrub_en = 1'b1;
      repeat (8) @(negedge clk);
      host_op(1'b1, 4'h5, 4'h7, 1'b0, lat, rd, er);
      chk("arb_host_first_lat", 32'(lat), 3);
      host_op(1'b0, 4'h5, 4'h0, 1'b0, lat, rd, er);
      chk("arb_host_delayed_lat", 32'(lat), 11);
      chk("arb_rd_data", 32'(rd), 32'h7);
      scrub_en = 1'b0;
      repeat (12) @(negedge clk);

      force_err = 1'b1;
      scrub_en  = 1'b1;
      wbn = 0;
      for (int i = 0; i < 3000 && wbn < 100; i++) begin
         @(negedge clk);
         if (!ncen && !nwen) wbn++;
      end
      chk("wb_count_100", 32'(wbn), 100);
      chk("corr_101", 32'(corr), 101);
      for (int i = 0; i < 5000 && wbn < 300; i++) begin
         @(negedge clk);
         if (!ncen && !nwen) wbn++;
      end
      chk("wb_count_300", 32'(wbn), 300);
      chk("corr_saturated", 32'(corr), 255);

      wait_cmd(1'b1, 40, got);
      chk("wbw_reached", 32'(got), 1);
      chk("busy_in_wbw", 32'(busy), 1);
      hreq = 1'b1; hwe = 1'b0; haddr = 4'h3; hdata = 4'h0; hfs = 1'b0;
      force_err = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("reset_mid_op", 32'({ncen, nwen, pa, pd, pfs, hack, hrdata, herr, busy, saddr, corr}),
          32'h3000_0000);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no_ack_in_reset", 32'(hack), 0);
      end
      rst_n = 1'b1;
      host_op(1'b0, 4'h3, 4'h0, 1'b0, lat, rd, er);
      chk("post_reset_host_lat", 32'(lat), 5);
      chk("post_reset_rd_data", 32'(rd), 32'hA);
      scrub_en = 1'b0;
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
